// File: rtl/bram_arbiter_pkg.sv
// Shared sizes and types for the BRAM arbiter and its round-robin sub-arbiters.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package bram_arb_pkg;

  localparam int NUM_REQ         = 4;
  localparam int BRAM_ADDR_WIDTH = 10;
  localparam int BRAM_DATA_WIDTH = 32;
  localparam int BE_WIDTH        = BRAM_DATA_WIDTH / 8;
  localparam int IDX_WIDTH       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef logic [BRAM_ADDR_WIDTH-1:0] addr_t;
  typedef logic [BRAM_DATA_WIDTH-1:0] data_t;
  typedef logic [BE_WIDTH-1:0]        be_t;
  typedef logic [NUM_REQ-1:0]         req_vec_t;
  typedef logic [IDX_WIDTH-1:0]       req_idx_t;

  // Next requester index with wrap-around; also used for non-power-of-two NUM_REQ.
  function automatic req_idx_t idx_inc(input req_idx_t i);
    if (i == req_idx_t'(NUM_REQ - 1)) begin
      return '0;
    end
    return req_idx_t'(i + 1'b1);
  endfunction

endpackage

// File: rtl/bram_arbiter_if.sv
// Agent-side bus of the BRAM arbiter: packed per-agent read/write requests and grants.
// Latency: grants combinational; read data one cycle after the read grant.
// Backpressure: requests are held by the agent until granted; responses cannot be stalled.
interface bram_arbiter_if;
  import bram_arb_pkg::*;

  logic [NUM_REQ-1:0]                 rd_req;
  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] rd_addr;
  logic [NUM_REQ-1:0]                 rd_gnt;
  logic [NUM_REQ-1:0]                 rd_rvalid;
  data_t                              rd_rdata;

  logic [NUM_REQ-1:0]                 wr_req;
  logic [NUM_REQ*BRAM_ADDR_WIDTH-1:0] wr_addr;
  logic [NUM_REQ*BE_WIDTH-1:0]        wr_be;
  logic [NUM_REQ*BRAM_DATA_WIDTH-1:0] wr_din;
  logic [NUM_REQ-1:0]                 wr_gnt;

  // Agents drive requests and consume grants/read data.
  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_din,
    input  rd_gnt, rd_rvalid, rd_rdata, wr_gnt
  );

  // The arbiter consumes requests and drives grants/read data.
  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_be, wr_din,
    output rd_gnt, rd_rvalid, rd_rdata, wr_gnt
  );

endinterface

// File: rtl/bram_arbiter_rr.sv
// Round-robin arbiter: first requester at or above the priority pointer wins, with wrap-around.
// Latency: grant combinational in the request cycle; pointer moves past the winner at the edge.
// Backpressure: none; a requester simply keeps req asserted until it sees its grant.
module rr_arbiter
  import bram_arb_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  req_vec_t req_vec,
  input  logic     advance,
  output req_vec_t gnt,
  output req_idx_t winner
);

  req_idx_t ptr_q;
  req_idx_t ptr_d;

  // Search from the pointer upward, wrapping, and pick the first active request.
  always_comb begin : search
    int       idx;
    req_idx_t cand;
    logic     found;
    idx    = 0;
    cand   = '0;
    found  = 1'b0;
    gnt    = '0;
    winner = ptr_q;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = int'(ptr_q) + off;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      cand = req_idx_t'(idx);
      if (!found && req_vec[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        winner    = cand;
      end
    end
  end

  // Pointer moves just past the winner; holds when nobody asked.
  always_comb begin
    ptr_d = ptr_q;
    if (advance && (|req_vec)) begin
      ptr_d = idx_inc(winner);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/bram_arbiter.sv
// Shares one bram_block (1 read, 1 byte-enabled write port) among NUM_REQ agents; optional RAW forwarding via BRAM_ARB_RAW_FWD_EN.
// Latency: grants and BRAM write/read address combinational; read data and rd_rvalid exactly 1 cycle after rd_gnt.
// Backpressure: requests wait for a grant; read responses have no stall path.
module bram_arbiter
  import bram_arb_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  bram_arbiter_if.slave        bus,
  output addr_t                bram_rd_addr,
  output addr_t                bram_wr_addr,
  output be_t                  bram_wr_en,
  output data_t                bram_din,
  input  data_t                bram_dout
);

  // reset is active-low: while it is asserted no request may be granted,
  // so the BRAM write enable drops immediately rather than at the next edge.
  req_vec_t rd_req_m;
  req_vec_t wr_req_m;
  req_vec_t rd_gnt;
  req_vec_t wr_gnt;
  req_idx_t rd_win;
  req_idx_t wr_win;

  addr_t    rd_addr_sel;
  addr_t    wr_addr_sel;
  be_t      wr_be_sel;
  data_t    wr_din_sel;

  req_vec_t rvalid_q;
  req_vec_t rvalid_d;
  data_t    rdata_merged;

  // Requests are masked while reset is asserted.
  always_comb begin
    rd_req_m = reset ? bus.rd_req : '0;
    wr_req_m = reset ? bus.wr_req : '0;
  end

  rr_arbiter u_rd_arb (
    .clk     (clock),
    .rst_n   (reset),
    .req_vec (rd_req_m),
    .advance (1'b1),
    .gnt     (rd_gnt),
    .winner  (rd_win)
  );

  rr_arbiter u_wr_arb (
    .clk     (clock),
    .rst_n   (reset),
    .req_vec (wr_req_m),
    .advance (1'b1),
    .gnt     (wr_gnt),
    .winner  (wr_win)
  );

  // Select the winners' fields; everything is zero when the port is idle.
  always_comb begin
    rd_addr_sel = '0;
    wr_addr_sel = '0;
    wr_be_sel   = '0;
    wr_din_sel  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) begin
        rd_addr_sel = bus.rd_addr[i*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
      end
      if (wr_gnt[i]) begin
        wr_addr_sel = bus.wr_addr[i*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH];
        wr_be_sel   = bus.wr_be[i*BE_WIDTH +: BE_WIDTH];
        wr_din_sel  = bus.wr_din[i*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH];
      end
    end
  end

  // The one-hot read grant becomes next cycle's one-hot response valid.
  always_comb begin
    rvalid_d = rd_gnt;
  end

  // Response register; async clear drops any in-flight response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= rvalid_d;
    end
  end

`ifdef BRAM_ARB_RAW_FWD_EN
  logic  fwd_hit_q;
  logic  fwd_hit_d;
  data_t fwd_data_q;
  data_t fwd_data_d;
  be_t   fwd_be_q;
  be_t   fwd_be_d;

  // Remember a same-cycle same-address write so the read sees the new bytes.
  always_comb begin
    fwd_hit_d  = (|rd_gnt) && (|wr_gnt) && (rd_addr_sel == wr_addr_sel);
    fwd_data_d = wr_din_sel;
    fwd_be_d   = wr_be_sel;
  end

  // Forward register, aligned with the read response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_be_q   <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
      fwd_be_q   <= fwd_be_d;
    end
  end

  // Overlay the forwarded bytes on the (old) BRAM data.
  always_comb begin
    rdata_merged = bram_dout;
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (fwd_hit_q && fwd_be_q[b]) begin
        rdata_merged[8*b +: 8] = fwd_data_q[8*b +: 8];
      end
    end
  end
`else
  // Without forwarding the BRAM's read-first data is returned as is.
  always_comb begin
    rdata_merged = bram_dout;
  end
`endif

  // Drive the BRAM and the agent-facing outputs.
  always_comb begin
    bram_rd_addr  = rd_addr_sel;
    bram_wr_addr  = wr_addr_sel;
    bram_wr_en    = wr_be_sel;
    bram_din      = wr_din_sel;
    bus.rd_gnt    = rd_gnt;
    bus.wr_gnt    = wr_gnt;
    bus.rd_rvalid = rvalid_q;
    bus.rd_rdata  = (|rvalid_q) ? rdata_merged : '0;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter with a read-first BRAM model; honours BRAM_ARB_RAW_FWD_EN.
// Latency: checks combinational grants in-cycle and read data one cycle later.
// Backpressure: n/a.
module tb_bram_arbiter;
  import bram_arb_pkg::*;

  logic  clock = 1'b0;
  logic  reset = 1'b0;
  addr_t bram_rd_addr;
  addr_t bram_wr_addr;
  be_t   bram_wr_en;
  data_t bram_din;
  data_t bram_dout;

  int n_chk = 0;
  int n_err = 0;

  data_t mem [0:(1<<BRAM_ADDR_WIDTH)-1];

  always #5 clock = ~clock;

  bram_arbiter_if bus ();

  bram_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .bram_rd_addr (bram_rd_addr),
    .bram_wr_addr (bram_wr_addr),
    .bram_wr_en   (bram_wr_en),
    .bram_din     (bram_din),
    .bram_dout    (bram_dout)
  );

  // Read-first BRAM model: dout registers the old word, then byte writes apply.
  initial begin
    for (int i = 0; i < (1<<BRAM_ADDR_WIDTH); i++) begin
      mem[i] = 32'hA000_0000 | i;
    end
    mem[9] = 32'h1122_3344;
    bram_dout = '0;
    forever begin
      @(posedge clock);
      bram_dout <= mem[bram_rd_addr];
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (bram_wr_en[b]) begin
          mem[bram_wr_addr][8*b +: 8] = bram_din[8*b +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.rd_req  = '0;
    bus.rd_addr = '0;
    bus.wr_req  = '0;
    bus.wr_addr = '0;
    bus.wr_be   = '0;
    bus.wr_din  = '0;
  endtask

  task automatic rd(input int a, input int addr);
    bus.rd_req[a] = 1'b1;
    bus.rd_addr[a*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH] = addr_t'(addr);
  endtask

  task automatic wr(input int a, input int addr, input int be, input logic [31:0] d);
    bus.wr_req[a] = 1'b1;
    bus.wr_addr[a*BRAM_ADDR_WIDTH +: BRAM_ADDR_WIDTH] = addr_t'(addr);
    bus.wr_be[a*BE_WIDTH +: BE_WIDTH] = be_t'(be);
    bus.wr_din[a*BRAM_DATA_WIDTH +: BRAM_DATA_WIDTH] = d;
  endtask

  task automatic cyc_end();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_raw;
    idle();
    // Reset held with live requests: nothing granted, nothing written.
    rd(0, 40);
    wr(0, 1, 4'hF, 32'hFFFF_FFFF);
    cyc_end();
    #2;
    chk("rst_wr_en",  32'(bram_wr_en),    32'h0);
    chk("rst_wr_gnt", 32'(bus.wr_gnt),    32'h0);
    chk("rst_rd_gnt", 32'(bus.rd_gnt),    32'h0);
    chk("rst_rvalid", 32'(bus.rd_rvalid), 32'h0);
    chk("rst_rdata",  bus.rd_rdata,       32'h0);

    // Release, grant a read so the pointer moves and a response is in flight.
    @(posedge clock);
    #1;
    reset = 1'b1;
    idle();
    rd(0, 40);
    #2;
    chk("pre_gnt", 32'(bus.rd_gnt), 32'h1);
    cyc_end();
    idle();
    wr(2, 50, 4'hF, 32'h1234_5678);
    #2;
    chk("pend_rvalid", 32'(bus.rd_rvalid), 32'h1);
    chk("pend_rdata",  bus.rd_rdata,       32'hA000_0028);
    reset = 1'b0;
    #1;
    chk("mid_rst_rvalid", 32'(bus.rd_rvalid), 32'h0);
    chk("mid_rst_wr_en",  32'(bram_wr_en),    32'h0);
    chk("mid_rst_rdata",  bus.rd_rdata,       32'h0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Round-robin with all four readers; first grant proves the pointer reset.
    idle();
    for (int i = 0; i < 4; i++) rd(i, 16 + i);
    for (int k = 0; k < 8; k++) begin
      #2;
      chk($sformatf("rr_gnt%0d", k), 32'(bus.rd_gnt), 32'(1 << (k % 4)));
      if (k == 0) begin
        chk("rr_rvalid0", 32'(bus.rd_rvalid), 32'h0);
      end else begin
        chk($sformatf("rr_rvalid%0d", k), 32'(bus.rd_rvalid), 32'(1 << ((k - 1) % 4)));
        chk($sformatf("rr_rdata%0d", k), bus.rd_rdata, 32'hA000_0010 + 32'((k - 1) % 4));
      end
      cyc_end();
    end
    idle();
    #2;
    chk("rr_rvalid_last", 32'(bus.rd_rvalid), 32'h8);
    chk("rr_rdata_last",  bus.rd_rdata,       32'hA000_0013);
    cyc_end();

    // Lone requester back-to-back at addresses 5,6,7.
    for (int k = 0; k < 3; k++) begin
      idle();
      rd(2, 5 + k);
      #2;
      chk($sformatf("lone_gnt%0d", k), 32'(bus.rd_gnt), 32'h4);
      chk($sformatf("lone_addr%0d", k), 32'(bram_rd_addr), 32'(5 + k));
      if (k > 0) begin
        chk($sformatf("lone_rdata%0d", k), bus.rd_rdata, 32'hA000_0005 + 32'(k - 1));
      end
      cyc_end();
    end
    idle();
    #2;
    chk("lone_rvalid3", 32'(bus.rd_rvalid), 32'h4);
    chk("lone_rdata3",  bus.rd_rdata,       32'hA000_0007);
    cyc_end();

    // Byte-enabled write by agent 2, then read back.
    idle();
    wr(2, 9, 4'b0101, 32'hAABB_CCDD);
    #2;
    chk("bw_gnt",   32'(bus.wr_gnt),   32'h4);
    chk("bw_en",    32'(bram_wr_en),   32'h5);
    chk("bw_addr",  32'(bram_wr_addr), 32'd9);
    chk("bw_din",   bram_din,          32'hAABB_CCDD);
    cyc_end();
    idle();
    rd(0, 9);
    cyc_end();
    idle();
    #2;
    chk("bw_rdata", bus.rd_rdata, 32'h11BB_33DD);
    cyc_end();

    // Same-cycle read and write of address 3.
`ifdef BRAM_ARB_RAW_FWD_EN
    exp_raw = 32'hDEAD_BEEF;
`else
    exp_raw = 32'hA000_0003;
`endif
    idle();
    wr(1, 3, 4'hF, 32'hDEAD_BEEF);
    rd(1, 3);
    #2;
    chk("raw_wr_gnt", 32'(bus.wr_gnt), 32'h2);
    chk("raw_rd_gnt", 32'(bus.rd_gnt), 32'h2);
    cyc_end();
    idle();
    rd(1, 3);
    #2;
    chk("raw_rdata", bus.rd_rdata, exp_raw);
    cyc_end();
    idle();
    #2;
    chk("raw_after", bus.rd_rdata, 32'hDEAD_BEEF);
    cyc_end();

    // Pointer reset, then contention on both ports at once.
    reset = 1'b0;
    #1;
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      idle();
      wr(1, 20, 4'hF, 32'h0000_0055);
      wr(3, 31, 4'h0, 32'hFFFF_FFFF);
      rd(1, 21);
      rd(2, 31);
      #2;
      chk($sformatf("ct_wr_gnt%0d", k), 32'(bus.wr_gnt), (k % 2 == 0) ? 32'h2 : 32'h8);
      chk($sformatf("ct_rd_gnt%0d", k), 32'(bus.rd_gnt), (k % 2 == 0) ? 32'h2 : 32'h4);
      chk($sformatf("ct_wr_en%0d", k),  32'(bram_wr_en), (k % 2 == 0) ? 32'hF : 32'h0);
      if (k > 0) begin
        chk($sformatf("ct_rvalid%0d", k), 32'(bus.rd_rvalid), (k % 2 == 1) ? 32'h2 : 32'h4);
        chk($sformatf("ct_rdata%0d", k), bus.rd_rdata, (k % 2 == 1) ? 32'hA000_0015 : 32'hA000_001F);
      end
      cyc_end();
    end
    idle();
    #2;
    chk("ct_rvalid4", 32'(bus.rd_rvalid), 32'h4);
    chk("ct_rdata4",  bus.rd_rdata,       32'hA000_001F);
    cyc_end();
    idle();
    rd(0, 20);
    cyc_end();
    idle();
    #2;
    chk("ct_wr_commit", bus.rd_rdata, 32'h0000_0055);
    cyc_end();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
